// File: rtl/line_sensor_adc_pkg.sv
// Shared definitions for the line-sensor ADC scanner: timing, channel map,
// threshold, orientation codes and small helper functions.
package line_sensor_adc_pkg;

    localparam int unsigned SCLK_HALF    = 8;
    localparam int unsigned CS_GAP       = 4;
    localparam int unsigned CNT_W        = 4;
    localparam int unsigned ADC_W        = 12;
    localparam int unsigned FILTER_SCANS = 2;

    localparam logic [2:0] CH_LEFT   = 3'd0;
    localparam logic [2:0] CH_CENTRE = 3'd1;
    localparam logic [2:0] CH_RIGHT  = 3'd2;

    localparam logic [ADC_W-1:0] WHITE_THRESHOLD = 12'd1000;

    localparam logic [3:0] ORIENT_UNKNOWN     = 4'd0;
    localparam logic [3:0] ORIENT_SOFT_LEFT   = 4'd1;
    localparam logic [3:0] ORIENT_ON_LINE     = 4'd2;
    localparam logic [3:0] ORIENT_SOFT_RIGHT  = 4'd3;
    localparam logic [3:0] ORIENT_RIGHT_NODE  = 4'd4;
    localparam logic [3:0] ORIENT_LEFT_NODE   = 4'd5;
    localparam logic [3:0] ORIENT_T_NODE      = 4'd6;
    localparam logic [3:0] ORIENT_WHITE_SPACE = 4'd7;

    typedef enum logic [1:0] {
        FR_IDLE  = 2'd0,
        FR_SETUP = 2'd1,
        FR_SHIFT = 2'd2,
        FR_GAP   = 2'd3
    } frame_state_t;

    // Address bit driven on DIN for a given SCLK period (1..16): ADD2..ADD0 on periods 3..5.
    function automatic logic addr_bit(input logic [2:0] ch, input logic [4:0] period);
        logic b;
        b = 1'b0;
        case (period)
            5'd3:    b = ch[2];
            5'd4:    b = ch[1];
            5'd5:    b = ch[0];
            default: b = 1'b0;
        endcase
        return b;
    endfunction

    // Map the white/black pattern {left, centre, right} (1 = white) to an orientation code.
    function automatic logic [3:0] classify(input logic l, input logic c, input logic r);
        logic [3:0] code;
        code = ORIENT_WHITE_SPACE;
        case ({l, c, r})
            3'b010:  code = ORIENT_ON_LINE;
            3'b100:  code = ORIENT_SOFT_LEFT;
            3'b001:  code = ORIENT_SOFT_RIGHT;
            3'b110:  code = ORIENT_LEFT_NODE;
            3'b011:  code = ORIENT_RIGHT_NODE;
            3'b111:  code = ORIENT_T_NODE;
            default: code = ORIENT_WHITE_SPACE;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/adc128s022_frame.sv
// One ADC128S022 SPI frame per request: SETUP, 16 SCLK periods, then CS gap.
// A request still high at the end of the gap chains straight into the next frame.
module adc128s022_frame
    import line_sensor_adc_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       channel,
    input  logic             adc_dout,
    output logic             adc_cs_n,
    output logic             adc_sclk,
    output logic             adc_din,
    output logic [ADC_W-1:0] data,
    output logic             done
);

    frame_state_t     state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [4:0]       half, half_next;
    logic [2:0]       chan_q, chan_next;
    logic [ADC_W-1:0] shreg, shreg_next;
    logic [ADC_W-1:0] data_next;
    logic             done_next;
    logic             cs_n_next, sclk_next, din_next;
    logic             half_done_c, gap_done_c;
    logic [4:0]       period_c;

    assign half_done_c = (cnt == CNT_W'(SCLK_HALF - 1));
    assign gap_done_c  = (cnt == CNT_W'(CS_GAP - 1));
    // SCLK period that begins when the current high half ends
    assign period_c    = {1'b0, half[4:1]} + 5'd2;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= FR_IDLE;
        else       state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            FR_IDLE:  if (start) state_next = FR_SETUP;
            FR_SETUP: if (half_done_c) state_next = FR_SHIFT;
            FR_SHIFT: if (half_done_c && (half == 5'd31)) state_next = FR_GAP;
            FR_GAP:   if (gap_done_c) state_next = start ? FR_SETUP : FR_IDLE;
            default:  state_next = FR_IDLE;
        endcase
    end

    // Output / datapath next values: pins, counters and the shift register
    always_comb begin
        cnt_next   = cnt + 1'b1;
        half_next  = half;
        chan_next  = chan_q;
        shreg_next = shreg;
        data_next  = data;
        done_next  = 1'b0;
        sclk_next  = adc_sclk;
        din_next   = adc_din;
        cs_n_next  = (state_next == FR_IDLE) || (state_next == FR_GAP);
        if (state_next != state) cnt_next = '0;
        if ((state_next == FR_SETUP) && (state != FR_SETUP)) begin
            chan_next = channel;
            sclk_next = 1'b1;
        end
        case (state)
            FR_IDLE: cnt_next = '0;
            FR_SETUP: begin
                if (half_done_c) begin
                    half_next = '0;
                    sclk_next = 1'b0;
                    din_next  = addr_bit(chan_q, 5'd1);
                end
            end
            FR_SHIFT: begin
                if (half_done_c) begin
                    cnt_next = '0;
                    if (half == 5'd31) begin
                        din_next  = 1'b0;
                        done_next = 1'b1;
                        data_next = shreg;
                    end else begin
                        half_next = half + 5'd1;
                        if (!half[0]) begin
                            // rising edge; periods 5..16 carry DB11..DB0
                            sclk_next = 1'b1;
                            if (half >= 5'd8) shreg_next = {shreg[ADC_W-2:0], adc_dout};
                        end else begin
                            sclk_next = 1'b0;
                            din_next  = addr_bit(chan_q, period_c);
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    // Registered pins, counters and captured data
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt      <= '0;
            half     <= '0;
            chan_q   <= '0;
            shreg    <= '0;
            data     <= '0;
            done     <= 1'b0;
            adc_cs_n <= 1'b1;
            adc_sclk <= 1'b1;
            adc_din  <= 1'b0;
        end else begin
            cnt      <= cnt_next;
            half     <= half_next;
            chan_q   <= chan_next;
            shreg    <= shreg_next;
            data     <= data_next;
            done     <= done_next;
            adc_cs_n <= cs_n_next;
            adc_sclk <= sclk_next;
            adc_din  <= din_next;
        end
    end

endmodule

// File: rtl/line_sensor_adc.sv
// Line-sensor scanner: sequences four ADC frames per scan (L, C, R, L with
// one-frame pipelined returns), thresholds the readings and filters the code.
module line_sensor_adc
    import line_sensor_adc_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        adc_dout,
    output logic        adc_cs_n,
    output logic        adc_sclk,
    output logic        adc_din,
    output logic [11:0] left_value,
    output logic [11:0] centre_value,
    output logic [11:0] right_value,
    output logic        sample_valid,
    output logic [3:0]  bot_orientation
);

    logic [1:0]       frame_idx;
    logic [ADC_W-1:0] left_tmp, centre_tmp;
    logic [3:0]       filt_cnt, prev_raw;
    logic             frame_start_c;
    logic [2:0]       frame_chan_c;
    logic             frame_done;
    logic [ADC_W-1:0] frame_data;
    logic [3:0]       raw_code_c, next_cnt_c;

    // Keep requesting frames mid-scan; a new scan only starts while enabled
    assign frame_start_c = enable || (frame_idx != 2'd0);

    // Channel addressed by the next frame
    always_comb begin
        frame_chan_c = CH_LEFT;
        case (frame_idx)
            2'd0:    frame_chan_c = CH_LEFT;
            2'd1:    frame_chan_c = CH_CENTRE;
            2'd2:    frame_chan_c = CH_RIGHT;
            default: frame_chan_c = CH_LEFT;
        endcase
    end

    // Classify the scan being completed (right reading arrives with the last frame)
    always_comb begin
        raw_code_c = classify(left_tmp < WHITE_THRESHOLD,
                              centre_tmp < WHITE_THRESHOLD,
                              frame_data < WHITE_THRESHOLD);
    end

    // Run-length of identical raw codes, saturating at 15
    always_comb begin
        next_cnt_c = 4'd1;
        if (raw_code_c == prev_raw) next_cnt_c = (filt_cnt == 4'hf) ? filt_cnt : filt_cnt + 4'd1;
    end

    adc128s022_frame u_frame (
        .clk      (clk),
        .reset    (reset),
        .start    (frame_start_c),
        .channel  (frame_chan_c),
        .adc_dout (adc_dout),
        .adc_cs_n (adc_cs_n),
        .adc_sclk (adc_sclk),
        .adc_din  (adc_din),
        .data     (frame_data),
        .done     (frame_done)
    );

    // Scan sequencer, result latching and orientation filter
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_idx       <= 2'd0;
            left_tmp        <= '0;
            centre_tmp      <= '0;
            left_value      <= '0;
            centre_value    <= '0;
            right_value     <= '0;
            sample_valid    <= 1'b0;
            bot_orientation <= ORIENT_UNKNOWN;
            filt_cnt        <= 4'd0;
            prev_raw        <= ORIENT_UNKNOWN;
        end else begin
            sample_valid <= 1'b0;
            if (frame_done) begin
                frame_idx <= frame_idx + 2'd1;
                case (frame_idx)
                    2'd1: left_tmp   <= frame_data;
                    2'd2: centre_tmp <= frame_data;
                    2'd3: begin
                        left_value   <= left_tmp;
                        centre_value <= centre_tmp;
                        right_value  <= frame_data;
                        sample_valid <= 1'b1;
                        prev_raw     <= raw_code_c;
                        filt_cnt     <= next_cnt_c;
                        if (next_cnt_c == 4'(FILTER_SCANS)) bot_orientation <= raw_code_c;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_line_sensor_adc.sv
// Bench for line_sensor_adc: behavioural ADC128S022 model plus a scan-level
// reference model of thresholding and filtering.
module tb_line_sensor_adc;

    localparam int SCAN_CLKS    = 1072;
    localparam int FIRST_CLKS   = 1070;
    localparam int FILTER_SCANS = 2;
    localparam int THRESH       = 1000;
    localparam int CS_GAP       = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        adc_dout;
    logic        adc_cs_n;
    logic        adc_sclk;
    logic        adc_din;
    logic [11:0] left_value;
    logic [11:0] centre_value;
    logic [11:0] right_value;
    logic        sample_valid;
    logic [3:0]  bot_orientation;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    line_sensor_adc dut (
        .clk             (clk),
        .reset           (reset),
        .enable          (enable),
        .adc_dout        (adc_dout),
        .adc_cs_n        (adc_cs_n),
        .adc_sclk        (adc_sclk),
        .adc_din         (adc_din),
        .left_value      (left_value),
        .centre_value    (centre_value),
        .right_value     (right_value),
        .sample_valid    (sample_valid),
        .bot_orientation (bot_orientation)
    );

    // ---------------- ADC model (sampled away from the active clock edge) ----------------
    logic [11:0] mem [0:7];
    logic [11:0] adc_v, adc_sh;
    logic [2:0]  addr_sr, prev_addr, cur_ch;
    logic        prev_cs_n = 1'b1, prev_sclk = 1'b1;
    int          fall_cnt = 0, rise_cnt = 0, gap_cnt = 0;
    bit          rec_en = 1'b0;
    int          frame_addr_q[$];
    int          frame_rise_q[$];
    int          gap_q[$];

    initial begin
        addr_sr   = 3'd0;
        prev_addr = 3'd0;
        cur_ch    = 3'd0;
    end

    always @(negedge clk) begin
        if (prev_cs_n && !adc_cs_n) begin
            fall_cnt = 0;
            rise_cnt = 0;
            addr_sr  = 3'd0;
            cur_ch   = prev_addr;
        end
        if (!prev_cs_n && adc_cs_n) begin
            prev_addr = addr_sr;
            if (rec_en) begin
                frame_addr_q.push_back(int'(addr_sr));
                frame_rise_q.push_back(rise_cnt);
            end
        end
        if (!adc_cs_n) begin
            if (!prev_sclk && adc_sclk) begin
                rise_cnt++;
                if (rise_cnt >= 3 && rise_cnt <= 5) addr_sr = {addr_sr[1:0], adc_din};
            end
            if (prev_sclk && !adc_sclk) begin
                fall_cnt++;
                if (fall_cnt >= 5 && fall_cnt <= 16) begin
                    adc_v    = mem[cur_ch];
                    adc_sh   = adc_v >> (16 - fall_cnt);
                    adc_dout = adc_sh[0];
                end else begin
                    adc_dout = 1'b0;
                end
            end
        end
        if (rec_en) begin
            if (adc_cs_n) gap_cnt++;
            else if (gap_cnt != 0) begin
                gap_q.push_back(gap_cnt);
                gap_cnt = 0;
            end
        end
        prev_cs_n = adc_cs_n;
        prev_sclk = adc_sclk;
    end

    // ---------------- Reference model ----------------
    int code_tbl [8] = '{7, 3, 2, 4, 1, 7, 5, 6};
    int m_prev   = -1;
    int m_run    = 0;
    int m_orient = 0;
    int exp_addr [4] = '{0, 1, 2, 0};

    task automatic set_readings(input int l, input int c, input int r);
        mem[0] = 12'(l);
        mem[1] = 12'(c);
        mem[2] = 12'(r);
    endtask

    task automatic model_reset();
        m_prev   = -1;
        m_run    = 0;
        m_orient = 0;
    endtask

    task automatic model_scan();
        int pat;
        int code;
        pat  = ((int'(mem[0]) < THRESH) ? 4 : 0) + ((int'(mem[1]) < THRESH) ? 2 : 0)
             + ((int'(mem[2]) < THRESH) ? 1 : 0);
        code = code_tbl[pat];
        if (code == m_prev) m_run++;
        else m_run = 1;
        m_prev = code;
        if (m_run == FILTER_SCANS) m_orient = code;
    endtask

    // ---------------- Checking ----------------
    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic wait_sv(output int cyc, output bit ok);
        cyc = 0;
        ok  = 1'b0;
        while (cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (sample_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_cs_falls(input int n, output bit ok);
        int   seen;
        int   cyc;
        logic last;
        seen = 0;
        cyc  = 0;
        last = adc_cs_n;
        while (cyc < 3000 && seen < n) begin
            @(negedge clk);
            cyc++;
            if (last && !adc_cs_n) seen++;
            last = adc_cs_n;
        end
        ok = (seen == n);
    endtask

    // Wait for the next scan result and compare it with the model; exp_cycles 0 skips timing.
    task automatic run_scan(input string tag, input int exp_cycles);
        int cyc;
        bit ok;
        wait_sv(cyc, ok);
        check({tag, ":pulse_seen"}, int'(ok), 1);
        if (!ok) return;
        if (exp_cycles > 0) check({tag, ":period"}, cyc, exp_cycles);
        model_scan();
        check({tag, ":left"}, int'(left_value), int'(mem[0]));
        check({tag, ":centre"}, int'(centre_value), int'(mem[1]));
        check({tag, ":right"}, int'(right_value), int'(mem[2]));
        check({tag, ":orient"}, int'(bot_orientation), m_orient);
    endtask

    function automatic int rand_reading();
        int sel;
        sel = int'($urandom_range(0, 3));
        case (sel)
            0:       return 999;
            1:       return 1000;
            2:       return int'($urandom_range(0, 999));
            default: return int'($urandom_range(1000, 4095));
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int  n_sv;
        int  n_low;
        bit  ok;
        int  nf;
        int  ng;

        reset    = 1'b1;
        enable   = 1'b0;
        adc_dout = 1'b0;
        set_readings(3000, 3000, 3000);
        for (int i = 3; i < 8; i++) mem[i] = 12'd0;
        repeat (3) @(negedge clk);

        check("rst:cs_n", int'(adc_cs_n), 1);
        check("rst:sclk", int'(adc_sclk), 1);
        check("rst:din", int'(adc_din), 0);
        check("rst:values", int'(left_value) + int'(centre_value) + int'(right_value), 0);
        check("rst:valid", int'(sample_valid), 0);
        check("rst:orient", int'(bot_orientation), 0);

        // Left on white only -> soft left after two scans
        reset  = 1'b0;
        rec_en = 1'b1;
        set_readings(300, 3000, 3000);
        enable = 1'b1;
        run_scan("a1", FIRST_CLKS);
        run_scan("a2", SCAN_CLKS);
        check("a:orient_is_1", int'(bot_orientation), 1);
        check("a:left_is_300", int'(left_value), 300);

        // Pin-level checks on the first two scans
        nf = frame_addr_q.size();
        check("pins:frames", int'(nf >= 8), 1);
        for (int i = 0; i < 8 && i < nf; i++) begin
            check($sformatf("pins:addr%0d", i), frame_addr_q[i], exp_addr[i % 4]);
            check($sformatf("pins:sclk%0d", i), frame_rise_q[i], 16);
        end
        ng = gap_q.size();
        check("pins:gaps", int'(ng >= 8), 1);
        for (int i = 1; i < 8 && i < ng; i++)
            check($sformatf("pins:gap%0d", i), int'(gap_q[i] >= CS_GAP), 1);

        // Centre on line, then right node with filtering delay
        set_readings(3000, 500, 3000);
        run_scan("b1", SCAN_CLKS);
        run_scan("b2", SCAN_CLKS);
        check("b:on_line", int'(bot_orientation), 2);
        set_readings(3000, 500, 500);
        run_scan("b3", SCAN_CLKS);
        check("b:held", int'(bot_orientation), 2);
        run_scan("b4", SCAN_CLKS);
        check("b:right_node", int'(bot_orientation), 4);

        // Threshold boundary
        set_readings(1000, 1000, 1000);
        run_scan("c1", SCAN_CLKS);
        run_scan("c2", SCAN_CLKS);
        check("c:thr_black", int'(bot_orientation), 7);
        set_readings(999, 999, 999);
        run_scan("c3", SCAN_CLKS);
        run_scan("c4", SCAN_CLKS);
        check("c:thr_white", int'(bot_orientation), 6);

        // Randomised readings, sometimes repeated so the filter settles
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 2) != 0) set_readings(rand_reading(), rand_reading(), rand_reading());
            run_scan($sformatf("r%0d", i), SCAN_CLKS);
        end

        // Reset in the middle of frame 3
        wait_cs_falls(3, ok);
        check("rst2:falls", int'(ok), 1);
        repeat (100) @(negedge clk);
        check("rst2:in_frame", int'(adc_cs_n), 0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rst2:cs_n", int'(adc_cs_n), 1);
        check("rst2:sclk", int'(adc_sclk), 1);
        check("rst2:orient", int'(bot_orientation), 0);
        check("rst2:valid", int'(sample_valid), 0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        run_scan("rs1", FIRST_CLKS);
        run_scan("rs2", SCAN_CLKS);

        // Drop enable during frame 2
        wait_cs_falls(2, ok);
        check("en:falls", int'(ok), 1);
        repeat (50) @(negedge clk);
        enable = 1'b0;
        run_scan("en1", 0);
        n_sv  = 0;
        n_low = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (sample_valid) n_sv++;
            if (!adc_cs_n) n_low++;
        end
        check("en:no_pulse", n_sv, 0);
        check("en:cs_idle", n_low, 0);
        check("en:orient_hold", int'(bot_orientation), m_orient);
        enable = 1'b1;
        @(posedge clk);
        #1;
        check("en:restart_cs", int'(adc_cs_n), 0);
        run_scan("en2", FIRST_CLKS - 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
